// File: rtl/bus_monitor.sv
// Passive monitor for the CPU to data_bus interface. It tracks the run state, the
// cycle and access counters, watchpoint hits, fault capture and a read-data signature.
module bus_monitor #(
    parameter int                 ADDR_W    = 64,
    parameter int                 DATA_W    = 64,
    parameter int                 NUM_WATCH = 4,
    parameter int                 CNT_W     = 32,
    parameter logic [ADDR_W-1:0]  END_ADDR  = ADDR_W'(64'h0000_0000_0000_FFFF),
    parameter int                 TIMEOUT   = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clear,
    input  logic                        bus_valid,
    input  logic                        rw,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           read,
    input  logic [DATA_W-1:0]           write,
    input  logic                        exception,
    input  logic [NUM_WATCH*ADDR_W-1:0] watch_addr,
    input  logic [NUM_WATCH-1:0]        watch_en,
    output logic                        running,
    output logic                        done,
    output logic                        fault,
    output logic                        timeout,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [CNT_W-1:0]            access_cnt,
    output logic [NUM_WATCH-1:0]        hit_mask,
    output logic [3:0]                  first_hit,
    output logic [ADDR_W-1:0]           fault_addr,
    output logic [DATA_W-1:0]           signature
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state;
    logic [NUM_WATCH-1:0] match;
    logic [3:0]           low_idx;
    logic [DATA_W-1:0]    sig_next;
    logic                 unused_bits;

    // Write data is only carried on the port for a future trace extension.
    assign unused_bits = ^write;

    always_comb begin
        match   = '0;
        low_idx = '0;
        for (int i = NUM_WATCH - 1; i >= 0; i--) begin
            match[i] = watch_en[i] && (addr == watch_addr[i*ADDR_W +: ADDR_W]);
            if (match[i]) low_idx = 4'(i);
        end
        sig_next = {signature[DATA_W-2:0], signature[DATA_W-1]} ^ read;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state      <= IDLE;
            running    <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
            access_cnt <= '0;
            hit_mask   <= '0;
            first_hit  <= '0;
            fault_addr <= '0;
            signature  <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        timeout    <= 1'b0;
                        cycle_cnt  <= '0;
                        access_cnt <= '0;
                        hit_mask   <= '0;
                        first_hit  <= '0;
                        fault_addr <= '0;
                        signature  <= '1;
                    end
                end
                RUN: begin
                    if (cycle_cnt != CNT_MAX) cycle_cnt <= cycle_cnt + 1'b1;
                    if (bus_valid) begin
                        if (access_cnt != CNT_MAX) access_cnt <= access_cnt + 1'b1;
                        if (!rw) signature <= sig_next;
                        hit_mask <= hit_mask | match;
                        if (hit_mask == '0 && match != '0) first_hit <= low_idx;
                    end
                    // Exception outranks end-of-run, which outranks the timeout.
                    if (bus_valid && exception) begin
                        state      <= FAULT;
                        running    <= 1'b0;
                        fault      <= 1'b1;
                        timeout    <= 1'b0;
                        fault_addr <= addr;
                    end else if (bus_valid && addr == END_ADDR) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (cycle_cnt == TO_LAST) begin
                        state      <= FAULT;
                        running    <= 1'b0;
                        fault      <= 1'b1;
                        timeout    <= 1'b1;
                        fault_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
